// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state type and oversampling constants.
// OVERSAMPLE : rx_baud_tick pulses per bit period
// MID_TICK   : tick count at the centre of the start bit
// LAST_TICK  : tick count at the end of a full bit period
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Generic 2-flop synchroniser for asynchronous single-bit inputs.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset; both flops load ResetVal
//   d     : asynchronous input
//   q     : synchronised output (2 clk latency)
module uart_rx_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises rx using the 16x oversampling tick and presents
// each word on a valid/ready interface with framing, parity and overrun status.
// Optional parity checking is compiled in with the macro UART_RX_PARITY_EN.
// Ports:
//   clk          : single clock
//   rst_n        : synchronous active-low reset
//   rx_baud_tick : one-clk pulse at 16x baud
//   rx           : asynchronous serial input, idles high
//   rx_data      : received word (LSB sent first)
//   rx_valid     : rx_data and status flags valid, held until accepted
//   rx_ready     : consumer accepts on rx_valid && rx_ready
//   frame_err    : stop bit sampled as 0 (qualified by rx_valid)
//   parity_err   : parity mismatch (qualified by rx_valid), 0 without parity
//   overrun_err  : one-clk pulse when a new frame overwrites an unaccepted word
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 frame_done;

  uart_rx_sync #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // Stop bit sampled at its centre; the FSM is back in idle on the same edge.
  assign frame_done = rx_baud_tick && (state == StStop) && (tick_cnt == LAST_TICK);

`ifdef UART_RX_PARITY_EN
  logic perr;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StIdle;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr        <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      if (rx_baud_tick) begin
        case (state)
          StIdle: begin
            if (!rx_s) begin
              state    <= StStart;
              tick_cnt <= '0;
            end
          end
          StStart: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == MID_TICK) begin
              if (!rx_s) begin
                state    <= StData;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state <= StIdle;
              end
            end
          end
          StData: begin
            // tick_cnt wraps to 0 after LAST_TICK on its own.
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= StParity;
`else
                state <= StStop;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          StParity: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
              perr  <= ^shift_reg ^ rx_s ^ PARITY_ODD;
              state <= StStop;
            end
          end
`endif
          StStop: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == LAST_TICK) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end

      overrun_err <= 1'b0;
      if (frame_done) begin
        rx_data     <= shift_reg;
        frame_err   <= ~rx_s;
        rx_valid    <= 1'b1;
        overrun_err <= rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
        parity_err  <= perr;
`endif
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned DataBits = 8;
  localparam bit          ParOdd   = 1'b0;
  localparam int unsigned TickDiv  = 27;
`ifdef UART_RX_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic                clk          = 1'b0;
  logic                rst_n        = 1'b0;
  logic                rx_baud_tick = 1'b0;
  logic                rx           = 1'b1;
  logic                rx_ready     = 1'b1;
  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                frame_err;
  logic                parity_err;
  logic                overrun_err;

  uart_rx #(
    .DATA_BITS (DataBits),
    .PARITY_ODD(ParOdd)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_baud_tick(rx_baud_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  // Stand-in for baud_rate_generator: one tick every TickDiv clocks.
  int unsigned div_cnt = 0;
  always @(posedge clk) begin
    if (div_cnt == TickDiv - 1) begin
      div_cnt      <= 0;
      rx_baud_tick <= 1'b1;
    end else begin
      div_cnt      <= div_cnt + 1;
      rx_baud_tick <= 1'b0;
    end
  end

  // Monitor: words accepted by the consumer and overrun pulse cycles.
  logic [9:0] got_q[$];
  int         ov_cycles = 0;
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) got_q.push_back({frame_err, parity_err, rx_data});
    if (overrun_err) ov_cycles++;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          rd_idx   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: what the consumer should see for a frame, from line-level bits.
  function automatic logic [9:0] model(input logic [7:0] data, input bit stop_bit,
                                       input bit par_bit);
    int ones;
    bit pe;
    ones = $countones(data) + int'(par_bit);
    pe   = ParityEn && (((ones % 2) == 1) != ParOdd);
    return {~stop_bit, pe, data};
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!rx_baud_tick);
    end
    #1;
  endtask

  // Drives one frame aligned to ticks; abort_at >= 0 resets the DUT during that data bit.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit par_bit,
                            input int abort_at);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < DataBits; i++) begin
      rx = data[i];
      if (i == abort_at) begin
        wait_ticks(5);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst rx_valid", 32'(rx_valid), 0);
        check("rst rx_data", 32'(rx_data), 0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst parity_err", 32'(parity_err), 0);
        check("rst overrun_err", 32'(overrun_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx    = 1'b1;
        return;
      end
      wait_ticks(16);
    end
    if (ParityEn) begin
      rx = par_bit;
      wait_ticks(16);
    end
    rx = stop_bit;
    wait_ticks(16);
    rx = 1'b1;
  endtask

  task automatic expect_word(input string tag, input logic [9:0] exp);
    int waited = 0;
    while (got_q.size() <= rd_idx && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " present"}, 32'(got_q.size() > rd_idx), 1);
    if (got_q.size() > rd_idx) begin
      check(tag, 32'(got_q[rd_idx]), 32'(exp));
      rd_idx++;
    end
  endtask

  initial begin
    logic [7:0] rnd_data;
    bit         rnd_par;
    int         ov_base;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init rx_valid", 32'(rx_valid), 0);
    check("init rx_data", 32'(rx_data), 0);
    check("init frame_err", 32'(frame_err), 0);
    check("init parity_err", 32'(parity_err), 0);
    check("init overrun_err", 32'(overrun_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ticks(8);

    // Good frame.
    send_frame(8'h55, 1'b1, 1'b0, -1);
    expect_word("good 55", model(8'h55, 1'b1, 1'b0));
    wait_ticks(8);

    // Start glitch, then a normal frame.
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(24);
    check("glitch rx_valid", 32'(rx_valid), 0);
    check("glitch words", 32'(got_q.size() - rd_idx), 0);
    send_frame(8'hC3, 1'b1, 1'b1, -1);
    expect_word("after glitch C3", model(8'hC3, 1'b1, 1'b1));
    wait_ticks(8);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      rnd_data = 8'($urandom);
      rnd_par  = 1'($urandom);
      send_frame(rnd_data, 1'b1, rnd_par, -1);
      expect_word("random", model(rnd_data, 1'b1, rnd_par));
      wait_ticks(8);
    end

    // Overrun: back-to-back with consumer stalled.
    rx_ready = 1'b0;
    ov_base  = ov_cycles;
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'h02, 1'b1, 1'b1, -1);
    @(negedge clk);
    check("ovr rx_valid", 32'(rx_valid), 1);
    check("ovr rx_data", 32'(rx_data), 32'h02);
    check("ovr pulse cycles", 32'(ov_cycles - ov_base), 1);
    check("ovr pulse ended", 32'(overrun_err), 0);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    expect_word("ovr accepted", model(8'h02, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    check("ovr valid cleared", 32'(rx_valid), 0);
    wait_ticks(8);

    // Same back-to-back pair with consumer ready: no overrun.
    ov_base = ov_cycles;
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'h02, 1'b1, 1'b1, -1);
    expect_word("b2b first", model(8'h01, 1'b1, 1'b1));
    expect_word("b2b second", model(8'h02, 1'b1, 1'b1));
    check("b2b no overrun", 32'(ov_cycles - ov_base), 0);
    wait_ticks(8);

    // Bad stop bit, held unaccepted so reset has something to clear.
    rx_ready = 1'b0;
    send_frame(8'hA3, 1'b0, 1'b0, -1);
    @(negedge clk);
    check("badstop rx_valid", 32'(rx_valid), 1);
    check("badstop rx_data", 32'(rx_data), 32'hA3);
    check("badstop frame_err", 32'(frame_err), 1);
    wait_ticks(32);
    check("badstop data held", 32'(rx_data), 32'hA3);

    // Reset during data bit 4 of 0xFF, then a clean frame.
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    wait_ticks(24);
    check("post-rst rx_valid", 32'(rx_valid), 0);
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    expect_word("post-rst 3C", model(8'h3C, 1'b1, 1'b0));
    wait_ticks(8);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    expect_word("parity bad", model(8'h07, 1'b1, 1'b0));
    wait_ticks(8);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    expect_word("parity good", model(8'h07, 1'b1, 1'b1));
    wait_ticks(8);
`endif

    check("no stray words", 32'(got_q.size() - rd_idx), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
